pll_reset_seq: RTL and testbench

Reset and lock sequencer for the three-output system PLL (25/50/100 MHz from the 50 MHz reference). Runs on the free-running reference clock, pulses the PLL reset, qualifies the PLL `locked` flag, then releases the per-clock-domain resets in a fixed staggered order. On loss of lock it re-asserts all domain resets immediately and restarts the sequence. Each domain's own 2-flop synchronizer consumes its reset output.

---
 rtl/pll_reset_seq.sv | 172 +++++++++++++++++
 tb/tb_pll_reset_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset pulse, lock qualification and staggered domain reset release
//
// Purpose:
//   Runs on the free-running reference clock. Pulses the PLL reset, waits for
//   the synchronized lock flag to stay high long enough, then releases the
//   three domain resets in ascending order (25 -> 50 -> 100 MHz). A lock loss
//   during release or run re-asserts every domain reset at once and restarts.
//
// Optional feature macro: PLL_SEQ_AUTORESET_EN
//   defined   : lock loss and lock-wait timeout both re-pulse the PLL reset.
//   undefined : lock loss returns to the lock wait without a PLL pulse; a
//               lock-wait timeout only raises o_timeout and keeps waiting.
//
// Ports:
//   i_refclk       in  1  reference clock, free-running
//   i_rst          in  1  synchronous active-high reset
//   i_pll_locked   in  1  PLL lock flag, asynchronous to i_refclk
//   o_pll_rst      out 1  PLL reset, active-high
//   o_rst_out      out 3  domain resets, active-high (bit0 25M, bit1 50M, bit2 100M)
//   o_ready        out 1  all domains released and lock held
//   o_timeout      out 1  sticky: lock wait expired at least once
//   o_relock_cnt   out 8  saturating count of lock losses after release began

module pll_reset_seq #(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int RELEASE_GAP_CYC  = 8
) (
  input  logic       i_refclk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  output logic       o_pll_rst,
  output logic [2:0] o_rst_out,
  output logic       o_ready,
  output logic       o_timeout,
  output logic [7:0] o_relock_cnt
);

  localparam int MAX_A = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int MAX_B = (LOCK_TIMEOUT_CYC > RELEASE_GAP_CYC) ? LOCK_TIMEOUT_CYC : RELEASE_GAP_CYC;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // One extra bit so the release phase can count across two gaps.
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP1_LAST   = CW'(RELEASE_GAP_CYC - 1);
  localparam logic [CW-1:0] GAP2_LAST   = CW'(2 * RELEASE_GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_pll_rst;
  logic [2:0]      r_rst_out;
  logic            r_ready;
  logic            r_timeout;
  logic [7:0]      r_relock_cnt;

  logic            w_lk;
  logic            w_lock_lost;

  assign w_lk = r_sync2;
  // Once any domain has been released, a lock drop is handled the same way.
  assign w_lock_lost = !w_lk && ((r_state == S_RELEASE) || (r_state == S_RUN));

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_state      <= S_RESET_PLL;
      r_cnt        <= '0;
      r_pll_rst    <= 1'b1;
      r_rst_out    <= 3'b111;
      r_ready      <= 1'b0;
      r_timeout    <= 1'b0;
      r_relock_cnt <= 8'd0;
    end else begin
      r_sync1 <= i_pll_locked;
      r_sync2 <= r_sync1;

      if (w_lock_lost) begin
        r_rst_out <= 3'b111;
        r_ready   <= 1'b0;
        r_cnt     <= '0;
        if (r_relock_cnt != 8'hFF) begin
          r_relock_cnt <= r_relock_cnt + 8'd1;
        end
`ifdef PLL_SEQ_AUTORESET_EN
        r_state   <= S_RESET_PLL;
        r_pll_rst <= 1'b1;
`else
        r_state   <= S_WAIT_LOCK;
`endif
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
        case (r_state)
          S_RESET_PLL: begin
            if (r_cnt == HOLD_LAST) begin
              r_state   <= S_WAIT_LOCK;
              r_pll_rst <= 1'b0;
              r_cnt     <= '0;
            end
          end
          S_WAIT_LOCK: begin
            if (w_lk) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == TMO_LAST) begin
              r_timeout <= 1'b1;
              r_cnt     <= '0;
`ifdef PLL_SEQ_AUTORESET_EN
              r_state   <= S_RESET_PLL;
              r_pll_rst <= 1'b1;
`endif
            end
          end
          S_STABLE: begin
            // Any dropout restarts both the stability count and the timeout.
            if (!w_lk) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == STABLE_LAST) begin
              r_state   <= S_RELEASE;
              r_rst_out <= 3'b110;
              r_cnt     <= '0;
            end
          end
          S_RELEASE: begin
            if (r_cnt == GAP1_LAST) begin
              r_rst_out[1] <= 1'b0;
            end
            if (r_cnt == GAP2_LAST) begin
              r_rst_out[2] <= 1'b0;
              r_ready      <= 1'b1;
              r_state      <= S_RUN;
              r_cnt        <= '0;
            end
          end
          S_RUN: begin
            r_cnt <= '0;
          end
          default: begin
            r_state   <= S_RESET_PLL;
            r_pll_rst <= 1'b1;
            r_rst_out <= 3'b111;
            r_ready   <= 1'b0;
            r_cnt     <= '0;
          end
        endcase
      end
    end
  end

  assign o_pll_rst    = r_pll_rst;
  assign o_rst_out    = r_rst_out;
  assign o_ready      = r_ready;
  assign o_timeout    = r_timeout;
  assign o_relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - scoreboard bench for pll_reset_seq with an event-time reference model

module tb_pll_reset_seq;

  localparam int H = 4;
  localparam int L = 16;
  localparam int T = 64;
  localparam int G = 2;
  localparam int N_DROPS = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll = 1'b0;
  logic       o_pll_rst;
  logic [2:0] o_rst_out;
  logic       o_ready;
  logic       o_timeout;
  logic [7:0] o_relock_cnt;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  // Output snapshot: {pll_rst, rst_out[2:0], ready, timeout, relock_cnt[7:0]}
  typedef struct {
    int          at;
    logic [13:0] val;
  } ev_t;

  ev_t         expq[$];
  logic [13:0] m_val;
  logic        m_to;
  int          m_rc;
  logic [13:0] prev;
  bit          armed = 1'b0;

  pll_reset_seq #(
    .RST_HOLD_CYC(H),
    .LOCK_STABLE_CYC(L),
    .LOCK_TIMEOUT_CYC(T),
    .RELEASE_GAP_CYC(G)
  ) dut (
    .i_refclk(clk),
    .i_rst(rst),
    .i_pll_locked(pll),
    .o_pll_rst(o_pll_rst),
    .o_rst_out(o_rst_out),
    .o_ready(o_ready),
    .o_timeout(o_timeout),
    .o_relock_cnt(o_relock_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output bundle must match the next expected event.
  always @(negedge clk) begin
    logic [13:0] obs;
    ev_t         e;
    if (armed) begin
      obs = {o_pll_rst, o_rst_out, o_ready, o_timeout, o_relock_cnt};
      if (obs !== prev) begin
        checks++;
        if (!(o_rst_out inside {3'b111, 3'b110, 3'b100, 3'b000}) ||
            (o_ready && (o_rst_out != 3'b000))) begin
          failures++;
          $display("FAIL invariant cyc=%0d rst_out=%b ready=%b required ascending release, ready only at 000",
                   cyc, o_rst_out, o_ready);
        end
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, obs);
        end else begin
          e = expq.pop_front();
          if ((e.at != cyc) || (e.val !== obs)) begin
            failures++;
            $display("FAIL event got cyc=%0d val=%b required cyc=%0d val=%b", cyc, obs, e.at, e.val);
          end
        end
        prev = obs;
      end
    end
  end

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pll_rst"}, 32'(o_pll_rst), 32'd1);
    chk({tag, ".rst_out"}, 32'(o_rst_out), 32'd7);
    chk({tag, ".ready"}, 32'(o_ready), 32'd0);
    chk({tag, ".timeout"}, 32'(o_timeout), 32'd0);
    chk({tag, ".relock_cnt"}, 32'(o_relock_cnt), 32'd0);
  endtask

  task automatic drive_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue an expected output change at cycle c (only if something changes).
  task automatic emit(input int c, input logic pr, input logic [2:0] ro, input logic rdy);
    logic [13:0] v;
    v = {pr, ro, rdy, m_to, m_rc[7:0]};
    if (v != m_val) begin
      expq.push_back('{at: c, val: v});
      m_val = v;
    end
  endtask

  // Reset held for 'hold' cycles; the PLL reset then stays high for H more cycles.
  task automatic do_reset(input logic lock_lvl, input int hold, output int d);
    int c0;
    c0 = cyc;
    d  = c0 + hold;
    m_to = 1'b0;
    m_rc = 0;
    emit(c0 + 1, 1'b1, 3'b111, 1'b0);
    emit(d + H, 1'b0, 3'b111, 1'b0);
    rst = 1'b1;
    pll = lock_lvl;
    drive_until(d);
    rst = 1'b0;
  endtask

  // Waiting for lock from cycle w0; pll_locked is high from cycle tl, so the
  // sequencer can see it from edge tl+3. Returns the edge a at which the
  // stability count begins.
  task automatic wait_lock(input int w0, input int tl, output int a);
    int w;
    bit done;
    w    = w0;
    done = 1'b0;
    while (!done) begin
      a = (w + 1 > tl + 3) ? w + 1 : tl + 3;
      if (a <= w + T) begin
        done = 1'b1;
      end else begin
        m_to = 1'b1;
`ifdef PLL_SEQ_AUTORESET_EN
        emit(w + T, 1'b1, 3'b111, 1'b0);
        emit(w + T + H, 1'b0, 3'b111, 1'b0);
        w = w + T + H;
`else
        emit(w + T, 1'b0, 3'b111, 1'b0);
        a    = tl + 3;
        done = 1'b1;
`endif
      end
    end
  endtask

  task automatic release_full(input int a, output int r);
    int rel;
    rel = a + L;
    emit(rel, 1'b0, 3'b110, 1'b0);
    emit(rel + G, 1'b0, 3'b100, 1'b0);
    emit(rel + 2 * G, 1'b0, 3'b000, 1'b1);
    r = rel + 2 * G;
  endtask

  // Lock loss seen at edge x; returns the cycle the lock wait restarts from.
  task automatic lose_lock(input int x, output int w);
    m_rc = sat_inc(m_rc);
`ifdef PLL_SEQ_AUTORESET_EN
    emit(x, 1'b1, 3'b111, 1'b0);
    emit(x + H, 1'b0, 3'b111, 1'b0);
    w = x + H;
`else
    emit(x, 1'b0, 3'b111, 1'b0);
    w = x;
`endif
  endtask

  initial begin
    int d, w, a, r, tl, x, g, f, rel, c;
    bit in_rel;

    rst = 1'b1;
    pll = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");
    m_to  = 1'b0;
    m_rc  = 0;
    m_val = {1'b1, 3'b111, 1'b0, 1'b0, 8'd0};
    prev  = m_val;
    armed = 1'b1;

    // Power-up with lock present throughout.
    do_reset(1'b1, rnd(1, 3), d);
    wait_lock(d + H, d, a);
    release_full(a, r);
    drive_until(r + rnd(2, 8));

    // Late lock, then a one-cycle dropout somewhere inside the stability count.
    do_reset(1'b0, rnd(1, 3), d);
    tl = d + rnd(0, 50);
    wait_lock(d + H, tl, a);
    x = a + rnd(1, L);
    g = x - 3;
    release_full(x + 1, r);
    drive_until(tl);
    pll = 1'b1;
    drive_until(g);
    pll = 1'b0;
    drive_until(g + 1);
    pll = 1'b1;
    drive_until(r + rnd(2, 8));

    // Lock arrives only after at least one timeout.
    do_reset(1'b0, rnd(1, 3), d);
    tl = d + H + T + rnd(0, 200);
    wait_lock(d + H, tl, a);
    release_full(a, r);
    drive_until(tl);
    pll = 1'b1;
    drive_until(r + 4);

    // Repeated lock losses in RUN or RELEASE; early ones are long enough to time out.
    f = cyc + rnd(1, 4);
    for (int i = 0; i < N_DROPS; i++) begin
      drive_until(f);
      pll = 1'b0;
      lose_lock(f + 3, w);
      tl = f + rnd(1, (i < 8) ? 150 : 6);
      wait_lock(w, tl, a);
      rel    = a + L;
      in_rel = (i < N_DROPS - 1) && (rnd(0, 2) == 0);
      emit(rel, 1'b0, 3'b110, 1'b0);
      if (in_rel) begin
        x = rel + rnd(1, 2 * G);
        if (x > rel + G) emit(rel + G, 1'b0, 3'b100, 1'b0);
      end else begin
        emit(rel + G, 1'b0, 3'b100, 1'b0);
        emit(rel + 2 * G, 1'b0, 3'b000, 1'b1);
        r = rel + 2 * G;
        x = r + rnd(1, 6);
      end
      drive_until(tl);
      pll = 1'b1;
      f = x - 3;
    end
    drive_until(r + 2);
    chk("relock_saturated", 32'(o_relock_cnt), 32'(m_rc));

    // Reset while rst_out=100 during RELEASE.
    f = cyc + rnd(1, 4);
    drive_until(f);
    pll = 1'b0;
    lose_lock(f + 3, w);
    tl = f + rnd(1, 6);
    wait_lock(w, tl, a);
    rel = a + L;
    emit(rel, 1'b0, 3'b110, 1'b0);
    emit(rel + G, 1'b0, 3'b100, 1'b0);
    c = rel + G + rnd(0, G - 1);
    drive_until(tl);
    pll = 1'b1;
    drive_until(c);
    do_reset(1'b1, 1, d);
    check_reset("rst_in_release");

    // Clean restart after that reset.
    wait_lock(d + H, d, a);
    release_full(a, r);
    drive_until(r + 5);

    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk("final_state", 32'({o_pll_rst, o_rst_out, o_ready, o_timeout, o_relock_cnt}), 32'(m_val));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
